// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the CORDIC custom-instruction front-end
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CORE_PERIOD = 5;
  localparam int FLOAT_W     = 32;
  localparam int FIXED_W     = 22;

  // Two full core periods plus one guarantees the core has latched and re-emitted the operand.
  localparam int HOLD_CYCLES_DEFAULT = 2 * CORE_PERIOD + 1;

endpackage

// File: rtl/cordic_ci_sequencer.sv
// rtl/cordic_ci_sequencer.sv - Nios II multi-cycle CI sequencer in front of the CORDIC core
module cordic_ci_sequencer
  import cordic_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               n,
  input  logic [FLOAT_W-1:0] dataa,
  output logic [FLOAT_W-1:0] result,
  output logic               done,
  output logic               busy,
  output logic [FLOAT_W-1:0] core_float_in,
  input  logic [FLOAT_W-1:0] core_float_out
);

  if ((2 ** CNT_W) <= HOLD_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLD_CYCLES");
  end
  if (HOLD_CYCLES < 2 * CORE_PERIOD + 1) begin : g_hold_check
    $error("HOLD_CYCLES shorter than two core periods plus one");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [FLOAT_W-1:0] result_d, core_float_in_d;
  logic               done_d, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      result        <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      core_float_in <= '0;
    end else if (clk_en) begin
      state         <= state_d;
      cnt           <= cnt_d;
      result        <= result_d;
      done          <= done_d;
      busy          <= busy_d;
      core_float_in <= core_float_in_d;
    end
  end

  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    result_d        = result;
    done_d          = 1'b0;
    busy_d          = busy;
    core_float_in_d = core_float_in;
    case (state)
      IDLE: begin
        if (start) begin
          if (n) begin
            result_d = dataa;
            done_d   = 1'b1;
          end else begin
            core_float_in_d = dataa;
            cnt_d           = '0;
            busy_d          = 1'b1;
            state_d         = HOLD;
          end
        end
      end
      HOLD: begin
        // Sample only once the operand has been stable for the whole settling window.
        if (cnt == CNT_LAST) begin
          result_d = core_float_out;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// tb/tb_cordic_ci_sequencer.sv - directed self-checking bench for cordic_ci_sequencer
module tb_cordic_ci_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic        n;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [31:0] core_float_in;
  logic [31:0] core_float_out = 32'h0;

  int checks = 0;
  int errors = 0;

  cordic_ci_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .start          (start),
    .n              (n),
    .dataa          (dataa),
    .result         (result),
    .done           (done),
    .busy           (busy),
    .core_float_in  (core_float_in),
    .core_float_out (core_float_out)
  );

  always #5 clk = ~clk;

  // Stub core: free-running 5-phase register pair returning the bitwise inverse of its input.
  logic [2:0]  phase   = 3'd0;
  logic [31:0] stub_in = 32'h0;
  always @(posedge clk) begin
    phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
    if (phase == 3'd0) stub_in <= core_float_in;
    if (phase == 3'd4) core_float_out <= ~stub_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Cosine request issued in cycle 0; cycle i is the interval after the i-th following edge.
  task automatic run_cos(input logic [31:0] a, input int second_at, input logic [31:0] second_data,
                         input int en_lo, input int en_hi,
                         output int first_done, output int dones,
                         output int busy_first, output int busy_last);
    first_done = -1; dones = 0; busy_first = -1; busy_last = -1;
    start = 1'b1; n = 1'b0; dataa = a; clk_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = i;
        busy_last = i;
      end
      start  = (i == second_at);
      dataa  = (i == second_at) ? second_data : a;
      clk_en = !(i >= en_lo && i <= en_hi);
    end
    start = 1'b0; clk_en = 1'b1;
  endtask

  int fd, nd, bf, bl;

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = 32'h0;

    // 1: reset then idle
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_core_in", core_float_in, 32'h0);

    // 2: basic cosine request
    run_cos(32'h3F800000, -1, 32'h0, -1, -1, fd, nd, bf, bl);
    check("cos_done_cycle", fd, 12);
    check("cos_done_count", nd, 1);
    check("cos_result", result, 32'hC07FFFFF);
    check("cos_busy_first", bf, 1);
    check("cos_busy_last", bl, 12);
    check("cos_core_in", core_float_in, 32'h3F800000);

    // 3: passthrough
    start = 1'b1; n = 1'b1; dataa = 32'h12345678;
    step();
    start = 1'b0; n = 1'b0;
    check("pt_done", {31'b0, done}, 32'h1);
    check("pt_result", result, 32'h12345678);
    check("pt_busy", {31'b0, busy}, 32'h0);
    check("pt_core_in", core_float_in, 32'h3F800000);
    step();
    check("pt_done_clear", {31'b0, done}, 32'h0);
    check("pt_result_hold", result, 32'h12345678);

    // 4: start during HOLD ignored
    run_cos(32'h40000000, 5, 32'h3F000000, -1, -1, fd, nd, bf, bl);
    check("ign_done_cycle", fd, 12);
    check("ign_done_count", nd, 1);
    check("ign_result", result, 32'hBFFFFFFF);
    check("ign_core_in", core_float_in, 32'h40000000);

    // 4b: start in the DONE cycle ignored
    run_cos(32'h3F800000, 12, 32'h3F000000, -1, -1, fd, nd, bf, bl);
    check("donestart_count", nd, 1);
    check("donestart_busy_last", bl, 12);
    check("donestart_core_in", core_float_in, 32'h3F800000);

    // 5: clk_en low for cycles 3..7
    run_cos(32'h3F800000, -1, 32'h0, 3, 7, fd, nd, bf, bl);
    check("en_done_cycle", fd, 17);
    check("en_done_count", nd, 1);
    check("en_result", result, 32'hC07FFFFF);
    check("en_busy_last", bl, 17);

    // 6: async reset mid-HOLD, then passthrough
    start = 1'b1; n = 1'b0; dataa = 32'h40000000;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 reset = 1'b1;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_core_in", core_float_in, 32'h0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    start = 1'b1; n = 1'b1; dataa = 32'hCAFEF00D;
    step();
    start = 1'b0; n = 1'b0;
    check("arst_pt_result", result, 32'hCAFEF00D);
    check("arst_pt_done", {31'b0, done}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
